// File: rtl/uart_pkg.sv
// Shared UART constants used by uartRx, the transmit path and the receive FIFO.
package uart_pkg;

    localparam int UART_CLK_PER_BIT   = 434;
    localparam int UART_DATA_W        = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo_mem.sv
// Byte storage for the receive FIFO: one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
module uart_rx_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: capture one byte per enabled cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : uart_rx_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind uartRx. Captures one byte per rising edge of
// rx_finish and presents it first-word-fall-through on a valid/ready port.
// Build option: define UART_RX_FIFO_OVERRUN_EN to get a sticky overrun flag
// (cleared by ovr_clr); otherwise overrun reads 0 and drops are silent.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_finish,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [LW-1:0]     level,
    output logic              full,
    output logic              overrun,
    input  logic              ovr_clr
);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              rx_finish_q;
    logic              push;
    logic              pop;
    logic              wr_en;
    logic              drop;
    logic [DATA_W-1:0] rd_data;

    // A stretched rx_finish must only write once, so push on its rising edge.
    assign push    = rx_finish & ~rx_finish_q;
    assign m_valid = (level != '0);
    assign full    = (level == LW'(DEPTH));
    assign pop     = m_valid & m_ready;
    // When full, a simultaneous pop frees the head slot, which is exactly wr_ptr.
    assign wr_en   = push & (~full | pop);
    assign drop    = push & full & ~pop;
    // Storage is not reset, so gate the head byte to keep m_data clean when empty.
    assign m_data  = m_valid ? rd_data : '0;

    uart_rx_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (rx_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Delay rx_finish by one cycle for the rising-edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_finish_q <= 1'b0;
        end else begin
            rx_finish_q <= rx_finish;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !wr_en) begin
                level <= level - LW'(1);
            end
        end
    end

`ifdef UART_RX_FIFO_OVERRUN_EN
    // Sticky overrun: a drop in the same cycle as ovr_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end
`else
    logic unused_ovr;

    assign overrun    = 1'b0;
    assign unused_ovr = ovr_clr ^ drop;
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: per-cycle vector table, hand-written corner
// sequences, and a negedge scoreboard that predicts occupancy and byte order.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_finish;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [4:0] level;
    logic       full;
    logic       overrun;
    logic       ovr_clr;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb[$];
    logic       prev_fin = 1'b0;
    logic       m_ovr    = 1'b0;
    logic [7:0] last_pop = 8'h00;

    uart_rx_fifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_finish (rx_finish),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .level     (level),
        .full      (full),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        rx_data   = d;
        rx_finish = 1'b1;
        tick();
        rx_finish = 1'b0;
        tick();
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int i = 0; i < 40 && m_valid; i++) tick();
        m_ready = 1'b0;
        check("drain_done", 32'(m_valid), 32'd0);
    endtask

    // Scoreboard: inputs are stable at negedge; predict the next posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prev_fin = 1'b0;
            m_ovr    = 1'b0;
        end else begin
            logic mpush;
            logic mdrop;
            check("sb_level", 32'(level), 32'(sb.size()));
            check("sb_valid", 32'(m_valid), 32'(sb.size() != 0));
            check("sb_full", 32'(full), 32'(sb.size() == DEPTH));
            check("sb_overrun", 32'(overrun), 32'(m_ovr));
            if (sb.size() != 0 && m_ready) begin
                check("sb_data", 32'(m_data), 32'(sb[0]));
                last_pop = sb.pop_front();
            end
            mpush    = rx_finish && !prev_fin;
            prev_fin = rx_finish;
            mdrop    = 1'b0;
            if (mpush) begin
                if (sb.size() < DEPTH) sb.push_back(rx_data);
                else mdrop = 1'b1;
            end
`ifdef UART_RX_FIFO_OVERRUN_EN
            if (mdrop) m_ovr = 1'b1;
            else if (ovr_clr) m_ovr = 1'b0;
`endif
        end
    end

    typedef struct {
        logic [7:0] d;
        logic       f;
        logic       r;
        int         lvl;
        logic       v;
        logic [7:0] hd;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{8'h93, 1'b1, 1'b0, 1, 1'b1, 8'h93};
        vecs[1]  = '{8'h93, 1'b0, 1'b0, 1, 1'b1, 8'h93};
        vecs[2]  = '{8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00};
        vecs[3]  = '{8'hA5, 1'b1, 1'b0, 1, 1'b1, 8'hA5};
        vecs[4]  = '{8'hA5, 1'b1, 1'b0, 1, 1'b1, 8'hA5};
        vecs[5]  = '{8'hA5, 1'b1, 1'b0, 1, 1'b1, 8'hA5};
        vecs[6]  = '{8'hA5, 1'b1, 1'b0, 1, 1'b1, 8'hA5};
        vecs[7]  = '{8'hA5, 1'b1, 1'b0, 1, 1'b1, 8'hA5};
        vecs[8]  = '{8'hA5, 1'b0, 1'b0, 1, 1'b1, 8'hA5};
        vecs[9]  = '{8'h3C, 1'b1, 1'b0, 2, 1'b1, 8'hA5};
        vecs[10] = '{8'h3C, 1'b0, 1'b1, 1, 1'b1, 8'h3C};
        vecs[11] = '{8'h3C, 1'b0, 1'b1, 0, 1'b0, 8'h00};
        vecs[12] = '{8'h11, 1'b1, 1'b0, 1, 1'b1, 8'h11};
        vecs[13] = '{8'h11, 1'b0, 1'b0, 1, 1'b1, 8'h11};
        vecs[14] = '{8'h22, 1'b1, 1'b1, 1, 1'b1, 8'h22};
        vecs[15] = '{8'h22, 1'b0, 1'b1, 0, 1'b0, 8'h00};

        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_finish = 1'b0;
        m_ready   = 1'b0;
        ovr_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("reset_valid", 32'(m_valid), 32'd0);
        check("reset_level", 32'(level), 32'd0);
        check("reset_full", 32'(full), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_data", 32'(m_data), 32'd0);

        for (int i = 0; i < 16; i++) begin
            rx_data   = vecs[i].d;
            rx_finish = vecs[i].f;
            m_ready   = vecs[i].r;
            tick();
            check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].lvl));
            check($sformatf("vec%0d_valid", i), 32'(m_valid), 32'(vecs[i].v));
            if (vecs[i].v) check($sformatf("vec%0d_data", i), 32'(m_data), 32'(vecs[i].hd));
        end
        rx_finish = 1'b0;
        m_ready   = 1'b0;
        tick();

        // Fill to the top, then overflow.
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
        check("fill_full", 32'(full), 32'd1);
        check("fill_level", 32'(level), 32'd16);
        check("fill_head", 32'(m_data), 32'h00);
        push_byte(8'hFF);
        check("ovf_level", 32'(level), 32'd16);
`ifdef UART_RX_FIFO_OVERRUN_EN
        check("ovf_overrun", 32'(overrun), 32'd1);
        rx_data   = 8'hEE;
        rx_finish = 1'b1;
        ovr_clr   = 1'b1;
        tick();
        rx_finish = 1'b0;
        ovr_clr   = 1'b0;
        check("ovf_set_wins", 32'(overrun), 32'd1);
        tick();
`else
        check("ovf_overrun_off", 32'(overrun), 32'd0);
`endif
        drain();
        check("ovf_last", 32'(last_pop), 32'h0F);
`ifdef UART_RX_FIFO_OVERRUN_EN
        check("ovr_sticky", 32'(overrun), 32'd1);
`endif
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);

        // Push and pop in the same cycle while full.
        for (int i = 0; i < DEPTH; i++) push_byte(8'h20 + 8'(i));
        check("sim_pre_level", 32'(level), 32'd16);
        rx_data   = 8'h55;
        rx_finish = 1'b1;
        m_ready   = 1'b1;
        tick();
        rx_finish = 1'b0;
        m_ready   = 1'b0;
        check("sim_level", 32'(level), 32'd16);
        check("sim_full", 32'(full), 32'd1);
        check("sim_overrun", 32'(overrun), 32'd0);
        check("sim_head", 32'(m_data), 32'h21);
        tick();
        drain();
        check("sim_last", 32'(last_pop), 32'h55);

        // Random consumer stalls across several pointer wraps.
        for (int i = 0; i < 40; i++) begin
            rx_data   = 8'($urandom);
            rx_finish = 1'b1;
            m_ready   = 1'($urandom_range(0, 1));
            tick();
            rx_finish = 1'b0;
            m_ready   = 1'($urandom_range(0, 1));
            tick();
        end
        drain();
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
        check("pre_rst_level", 32'(level), 32'd5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(m_valid), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_full", 32'(full), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        push_byte(8'h7E);
        check("post_rst_level", 32'(level), 32'd1);
        check("post_rst_data", 32'(m_data), 32'h7E);
        drain();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx_fifo
